seq_generator: RTL and testbench
================================

SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter PATTERN_W, default 12, pattern length in bits (legal range 2..32).
REQ-002 Parameter REPEAT_W, default 4, width of the repeat-count input.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pat_i  input  PATTERN_W  pattern to send, MSB first; captured on the accepted start.
REQ-007 rep_i  input  REPEAT_W  extra repetitions; rep_i+1 back-to-back copies are sent; captured on the accepted start.
REQ-008 ready_i  input  1  sink accepts the current bit this cycle when high.
REQ-009 abort_i  input  1  terminate the current transmission.
REQ-010 x_o  output  1  serial data bit; 0 whenever valid_o is 0.
REQ-011 valid_o  output  1  x_o carries a pattern bit.
REQ-012 last_o  output  1  high with the final bit of the final copy.
REQ-013 busy_o  output  1  high in SEND state.
REQ-014 done_o  output  1  one-cycle pulse after the final bit is accepted.

Function
REQ-015 The FSM SHALL have two states, IDLE and SEND; all outputs SHALL be registered.
REQ-016 A start is accepted when start_i=1 in IDLE; pat_i/rep_i are captured and the state enters SEND on the next edge.
REQ-017 In the first SEND cycle the block SHALL present x_o=pat_i[PATTERN_W-1] and valid_o=1; the latency from start to first bit is 1 cycle.
REQ-018 A bit is transferred when valid_o=1 and ready_i=1; the next bit (MSB to LSB order) SHALL appear on the following cycle.
REQ-019 While ready_i=0 the block SHALL hold x_o, valid_o, last_o and all internal counters unchanged, with no limit on stall length.
REQ-020 After the LSB of a copy transfers with copies remaining, the shift register SHALL reload the captured pattern and the MSB of the next copy SHALL follow on the next cycle with no gap.
REQ-021 The bit index counter SHALL span 0..PATTERN_W-1 and wrap to 0 on each reload.
REQ-022 The repeat counter SHALL load rep_i, decrement once per completed non-final copy and never underflow.
REQ-023 last_o SHALL be 1 only while the LSB of the final copy is presented (bit index PATTERN_W-1 and repeat counter 0).
REQ-024 When the last_o bit transfers, the block SHALL enter IDLE; the next cycle SHALL have done_o=1, valid_o=0 and busy_o=0.
REQ-025 start_i SHALL be accepted in the cycle that done_o=1, allowing back-to-back transmissions separated by exactly one idle cycle.
REQ-026 start_i in SEND SHALL be ignored and SHALL NOT alter the captured pattern or count.
REQ-027 abort_i=1 in SEND SHALL force IDLE on the next edge with valid_o=0, last_o=0 and no done_o pulse.
REQ-028 If abort_i and the final transfer coincide, abort SHALL win and done_o SHALL NOT pulse.
REQ-029 abort_i in IDLE SHALL have no effect, and abort_i SHALL take priority over start_i in the same cycle.
REQ-030 Changes to pat_i/rep_i after capture SHALL NOT affect the transmission in progress.

Reset
REQ-031 reset SHALL take priority over all other inputs.
REQ-032 During reset the block SHALL force IDLE, x_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, and clear the shift register, bit index and repeat counter.
REQ-033 Reset mid-transmission SHALL discard the transfer with no done_o pulse; a start in the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-034 Single copy, pat_i=12'hEDB, rep_i=0, ready_i=1 -> x_o = 1,1,1,0,1,1,0,1,1,0,1,1 on 12 consecutive cycles starting 1 cycle after start; last_o on the 12th bit; done_o on the cycle after.
REQ-035 rep_i=2, ready_i=1 -> 36 contiguous valid bits (pattern x3); last_o only on bit 36; exactly one done_o pulse.
REQ-036 ready_i low for 5 cycles at bit 4, then 1 cycle at bit 11 -> x_o holds through each stall; the bit sequence is unchanged; total 18 valid cycles.
REQ-037 abort_i at bit 7 -> valid_o=0 the next cycle, no done_o; abort_i coincident with the last_o transfer -> no done_o.
REQ-038 start_i pulsed with a different pat_i during SEND -> ignored, original bits sent; start_i asserted together with done_o -> new MSB appears 1 cycle later.
REQ-039 reset at bit 5 -> all outputs 0 next cycle; loopback into the 12-bit detector with 12'hEDB -> detector fires once per copy.

Source files
------------

// File: rtl/seq_generator.sv
// Serial pattern generator: shifts a captured pattern out MSB first, rep_i+1 times,
// with a valid/ready handshake, abort and a done pulse after the final bit.
module seq_generator #(
    parameter int unsigned PATTERN_W = 12,
    parameter int unsigned REPEAT_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [PATTERN_W-1:0] pat_i,
    input  logic [REPEAT_W-1:0]  rep_i,
    input  logic                 ready_i,
    input  logic                 abort_i,
    output logic                 x_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned IdxW = $clog2(PATTERN_W);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PATTERN_W - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e                state_q, state_d;
    logic [PATTERN_W-1:0]  pat_q, pat_d;
    logic [PATTERN_W-1:0]  shreg_q, shreg_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [REPEAT_W-1:0]   rep_q, rep_d;
    logic                  x_q, x_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IdxW-1:0]       idx_inc;

    assign idx_inc = idx_q + IdxW'(1);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        x_d     = x_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                x_d     = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                // abort outranks start even while idle
                if (start_i && !abort_i) begin
                    state_d = StSend;
                    pat_d   = pat_i;
                    shreg_d = pat_i;
                    idx_d   = '0;
                    rep_d   = rep_i;
                    x_d     = pat_i[PATTERN_W-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StSend: begin
                if (abort_i) begin
                    state_d = StIdle;
                    x_d     = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (ready_i) begin
                    if (last_q) begin
                        state_d = StIdle;
                        x_d     = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (idx_q == IdxLast) begin
                        // copy boundary: reload, next copy's MSB follows with no gap
                        shreg_d = pat_q;
                        idx_d   = '0;
                        rep_d   = rep_q - REPEAT_W'(1);
                        x_d     = pat_q[PATTERN_W-1];
                        last_d  = 1'b0;
                    end else begin
                        shreg_d = shreg_q << 1;
                        idx_d   = idx_inc;
                        x_d     = shreg_q[PATTERN_W-2];
                        last_d  = (idx_inc == IdxLast) && (rep_q == '0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pat_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_o     = x_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: vector table, directed corner sequences and random stimulus
// checked against a bit-queue reference model.
module tb_seq_generator;

    localparam int unsigned PW = 12;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [PW-1:0] pat_i;
    logic [RW-1:0] rep_i;
    logic          ready_i;
    logic          abort_i;
    logic          x_o, valid_o, last_o, busy_o, done_o;

    always #5 clk = ~clk;

    seq_generator #(.PATTERN_W(PW), .REPEAT_W(RW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_i),
        .pat_i   (pat_i),
        .rep_i   (rep_i),
        .ready_i (ready_i),
        .abort_i (abort_i),
        .x_o     (x_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    typedef struct {
        logic          start;
        logic [PW-1:0] pat;
        logic [RW-1:0] rep;
        logic          ready;
        logic          abort;
        logic [4:0]    exp;  // {x, valid, last, busy, done}
    } vec_t;

    vec_t tbl[16];

    int checks = 0;
    int errors = 0;

    // reference model: the bits still to be sent, front = bit currently presented
    bit   mq[$];
    logic m_busy = 1'b0;
    logic m_done = 1'b0;

    // statistics per directed sequence
    int            xfer_cnt, valid_cnt, done_cnt, last_cnt, hits;
    logic [PW-1:0] col, det;

    function automatic logic [4:0] m_exp();
        logic xb;
        xb = m_busy ? mq[0] : 1'b0;
        return {xb, m_busy, m_busy && (mq.size() == 1), m_busy, m_done};
    endfunction

    function automatic logic [4:0] act();
        return {x_o, valid_o, last_o, busy_o, done_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic [PW-1:0] p, input logic [RW-1:0] r,
                              input logic rd, input logic ab, input logic rs);
        if (rs) begin
            mq.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (ab) begin
                m_busy = 1'b0;
                mq.delete();
            end else if (rd) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (s && !ab) begin
                for (int c = 0; c <= int'(r); c++)
                    for (int i = PW - 1; i >= 0; i--) mq.push_back(p[i]);
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic clr_stats();
        xfer_cnt  = 0;
        valid_cnt = 0;
        done_cnt  = 0;
        last_cnt  = 0;
        hits      = 0;
        col       = '0;
        det       = '0;
    endtask

    // one clock: drive, advance model, check all outputs after the edge
    task automatic cyc(input logic s, input logic [PW-1:0] p, input logic [RW-1:0] r,
                       input logic rd, input logic ab, input logic rs);
        start_i = s;
        pat_i   = p;
        rep_i   = r;
        ready_i = rd;
        abort_i = ab;
        reset   = rs;
        if (!rs && !ab && valid_o && rd) begin
            xfer_cnt++;
            col = {col[PW-2:0], x_o};
            det = {det[PW-2:0], x_o};
            if (det == 12'hEDB) hits++;
        end
        model_step(s, p, r, rd, ab, rs);
        @(posedge clk);
        #1;
        chk("cycle", 32'(act()), 32'(m_exp()));
        if (done_o) done_cnt++;
        if (valid_o) valid_cnt++;
        if (last_o) last_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [PW-1:0] bits;
        int            sa, sb;
        logic          rd;

        bits = 12'hEDB;
        for (int k = 0; k < 12; k++) begin
            tbl[k].start = (k == 0);
            tbl[k].pat   = (k == 0) ? 12'hEDB : 12'h000;
            tbl[k].rep   = '0;
            tbl[k].ready = 1'b1;
            tbl[k].abort = 1'b0;
            tbl[k].exp   = {bits[11-k], 1'b1, (k == 11), 1'b1, 1'b0};
        end
        for (int k = 12; k < 16; k++) begin
            tbl[k].start = (k == 14);
            tbl[k].pat   = 12'hFFF;
            tbl[k].rep   = '0;
            tbl[k].ready = 1'b1;
            tbl[k].abort = (k >= 14);
            tbl[k].exp   = (k == 12) ? 5'b00001 : 5'b00000;
        end

        start_i = 1'b0; pat_i = '0; rep_i = '0; ready_i = 1'b0; abort_i = 1'b0; reset = 1'b1;
        clr_stats();
        cyc(1'b1, 12'hFFF, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("reset_state", 32'(act()), 32'd0);

        // single copy of EDB, started in the first cycle after reset
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].start, tbl[k].pat, tbl[k].rep, tbl[k].ready, tbl[k].abort, 1'b0);
            chk("table", 32'(act()), 32'(tbl[k].exp));
        end

        // three copies back to back, looped into the EDB detector
        clr_stats();
        cyc(1'b1, 12'hEDB, 4'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 39; i++) cyc(1'b0, 12'h000, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("rep2_valid", 32'(valid_cnt), 32'd36);
        chk("rep2_last", 32'(last_cnt), 32'd1);
        chk("rep2_done", 32'(done_cnt), 32'd1);
        chk("rep2_detect", 32'(hits), 32'd3);

        // stalls: 5 cycles on bit 4, 1 cycle on bit 11
        clr_stats();
        sa = 0; sb = 0;
        cyc(1'b1, 12'hEDB, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) begin
            if (xfer_cnt == 4 && sa < 5) begin rd = 1'b0; sa++; end
            else if (xfer_cnt == 11 && sb < 1) begin rd = 1'b0; sb++; end
            else rd = 1'b1;
            cyc(1'b0, 12'h000, 4'd0, rd, 1'b0, 1'b0);
        end
        chk("stall_valid", 32'(valid_cnt), 32'd18);
        chk("stall_bits", 32'(col), 32'hEDB);
        chk("stall_done", 32'(done_cnt), 32'd1);

        // abort while bit 7 is presented
        clr_stats();
        cyc(1'b1, 12'hEDB, 4'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        idle(3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // abort coinciding with the final transfer
        clr_stats();
        cyc(1'b1, 12'hEDB, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("last_before_abort", 32'(last_o), 32'd1);
        cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("abort_last_no_done", 32'(done_cnt), 32'd0);

        // start during SEND is ignored; start on done is accepted
        clr_stats();
        cyc(1'b1, 12'hEDB, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            cyc(i == 3, (i == 3) ? 12'h123 : 12'h000, (i == 3) ? 4'd5 : 4'd0, 1'b1, 1'b0, 1'b0);
        chk("ignore_start_bits", 32'(col), 32'hEDB);
        chk("ignore_start_valid", 32'(valid_cnt), 32'd12);
        chk("done_pulse", 32'(done_o), 32'd1);
        cyc(1'b1, 12'hA5C, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("b2b_msb", 32'({valid_o, x_o}), 32'b11);
        idle(13);

        // reset while bit 5 is presented
        clr_stats();
        cyc(1'b1, 12'hEDB, 4'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("reset_mid", 32'(act()), 32'd0);
        idle(3);
        chk("reset_mid_no_done", 32'(done_cnt), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, PW'($urandom), RW'($urandom_range(0, 2)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
